battle_turn_scheduler: RTL
==========================

// Module: battle_turn_scheduler
// PURPOSE
//  Game-flow controller for the 5x5 battleship game. Sequences the player and PC setup phases,
//  then alternates turns between player and PC, arbitrating shots onto a shared board-read port.
//  Tracks hits per side and detects the winner. Sits between the setup blocks, the board
//  storage and the display/LED logic.
// PARAMETERS
//  BOARD_N       5    board side length; legal coordinates are 0..BOARD_N-1
//  NUM_SHIPS     5    hits needed to win; matches the cant_barco ship count
//  TURN_TIMEOUT  1000 player-turn idle cycles before forfeit; 0 disables timeout
// PORTS
//  clk              in   1  system clock, rising edge
//  rst              in   1  asynchronous reset, active-low
//  start            in   1  pulse: leave IDLE, begin setup
//  restart          in   1  pulse: GAME_OVER -> IDLE
//  player_end_setup in   1  player setup complete (level)
//  pc_end_setup     in   1  PC setup complete (level)
//  en_player_setup  out  1  enables player setup block
//  en_pc_setup      out  1  enables PC random setup block
//  player_shot_vld  in   1  player requests shot
//  player_x/y       in   3  player target coordinate
//  pc_shot_vld      in   1  PC requests shot
//  pc_x/y           in   3  PC target coordinate
//  shot_ack         out  1  1-cycle pulse: current requester's shot accepted
//  shot_nack        out  1  1-cycle pulse: shot rejected (wrong turn excluded, see below)
//  rd_en            out  1  board read strobe
//  rd_sel           out  1  0 = read pc_board (player fires); 1 = read player_board
//  rd_x/rd_y        out  3  read coordinate
//  rd_hit           in   1  ship present; valid exactly 1 cycle after rd_en
//  mark_we          out  1  1-cycle pulse: record shot result at rd_sel/rd_x/rd_y
//  mark_hit         out  1  result written with mark_we
//  player_turn      out  1  high in PLAYER_TURN/PLAYER_RESOLVE
//  player_hits      out  3  hits scored by player
//  pc_hits          out  3  hits scored by PC
//  timeout          out  1  1-cycle pulse: player turn forfeited
//  game_over        out  1  high in GAME_OVER
//  winner           out  1  0 = player, 1 = PC; valid when game_over
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; hit counters, shot masks and timeout counter cleared.
//  States:
//   IDLE -start-> SETUP_P.
//   SETUP_P: en_player_setup=1; on player_end_setup -> SETUP_PC.
//   SETUP_PC: en_pc_setup=1; on pc_end_setup -> PLAYER_TURN.
//   PLAYER_TURN: accepts player_shot_vld only; PC requests ignored, no nack.
//   PLAYER_RESOLVE, PC_TURN, PC_RESOLVE: mirror of the player states.
//   GAME_OVER -restart-> IDLE. restart is ignored in all other states.
//  Shot accept (same cycle): requires coordinate < BOARD_N on both axes and the cell's bit
//   in that side's 25-bit shot mask clear. On accept: shot_ack=1, rd_en=1, rd_sel/rd_x/rd_y
//   driven; next state is *_RESOLVE. On reject: shot_nack=1; state unchanged.
//  RESOLVE (1 cycle): sample rd_hit; mark_we=1 with mark_hit=rd_hit at the latched
//   coordinate; set the mask bit; increment the side's counter if hit. If the new count equals
//   NUM_SHIPS -> GAME_OVER, winner=side. Otherwise -> the other side's TURN.
//  Accept latency: shot_vld -> mark_we = 1 cycle; at most one shot in flight.
//  Timeout: counter runs only in PLAYER_TURN and clears on turn entry. At count
//   TURN_TIMEOUT-1 with no accepted shot: timeout=1, -> PC_TURN. An accept in the same cycle
//   wins over the timeout. The PC turn has no timeout.
//  Counters saturate at NUM_SHIPS. Masks clear on reset and on the IDLE->SETUP_P transition.
//  Async reset mid-game aborts immediately. An in-flight mark_we is lost, by design.
// TESTING
//  1 reset -> all outputs 0; start, player_end_setup, pc_end_setup -> en_player_setup then
//    en_pc_setup each high >=1 cycle; player_turn=1.
//  2 player shot (2,3), rd_hit=1 -> shot_ack; rd_sel=0; mark_we next cycle with mark_hit=1;
//    player_hits=1; PC_TURN.
//  3 repeat shot (2,3), or x=5 -> shot_nack; no rd_en; state unchanged.
//  4 TURN_TIMEOUT=8, player idle -> timeout pulse on the 8th cycle, then PC_TURN; with vld on
//    that cycle -> ack, no timeout.
//  5 five player hits interleaved with PC misses -> game_over=1, winner=0; restart -> IDLE,
//    hits reset.
//  6 assert rst low during PC_RESOLVE -> outputs 0 immediately; IDLE on release.

Source files
------------

// File: rtl/battle_turn_scheduler.sv
// Battleship game-flow FSM: setup sequencing, alternating turns, shot arbitration, hit tally, winner.
// Latency: shot accepted combinationally in the turn state; mark_we follows exactly one cycle later.
// Backpressure: one shot in flight; requests outside the owner's turn are ignored, illegal/repeat shots nacked.
module battle_turn_scheduler #(
    parameter int BOARD_N      = 5,
    parameter int NUM_SHIPS    = 5,
    parameter int TURN_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       restart,
    input  logic       player_end_setup,
    input  logic       pc_end_setup,
    output logic       en_player_setup,
    output logic       en_pc_setup,
    input  logic       player_shot_vld,
    input  logic [2:0] player_x,
    input  logic [2:0] player_y,
    input  logic       pc_shot_vld,
    input  logic [2:0] pc_x,
    input  logic [2:0] pc_y,
    output logic       shot_ack,
    output logic       shot_nack,
    output logic       rd_en,
    output logic       rd_sel,
    output logic [2:0] rd_x,
    output logic [2:0] rd_y,
    input  logic       rd_hit,
    output logic       mark_we,
    output logic       mark_hit,
    output logic       player_turn,
    output logic [2:0] player_hits,
    output logic [2:0] pc_hits,
    output logic       timeout,
    output logic       game_over,
    output logic       winner
);

    localparam int              CELLS    = BOARD_N * BOARD_N;
    localparam int              TW       = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [3:0]      NB       = 4'(BOARD_N);
    localparam logic [2:0]      NS       = 3'(NUM_SHIPS);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TURN_TIMEOUT - 1);
    localparam bit              TMO_EN   = (TURN_TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE, SETUP_P, SETUP_PC, PLAYER_TURN, PLAYER_RESOLVE, PC_TURN, PC_RESOLVE, GAME_OVER
    } state_t;

    state_t           state;
    logic [CELLS-1:0] p_mask;
    logic [CELLS-1:0] c_mask;
    logic [2:0]       lat_x;
    logic [2:0]       lat_y;
    logic [5:0]       lat_idx;
    logic [TW-1:0]    tmo_cnt;
    logic [2:0]       p_hits_r;
    logic [2:0]       c_hits_r;
    logic             winner_r;

    function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return {3'b0, y} * 6'(BOARD_N) + {3'b0, x};
    endfunction

    function automatic logic in_range(input logic [2:0] x, input logic [2:0] y);
        return ({1'b0, x} < NB) && ({1'b0, y} < NB);
    endfunction

    // Masks are widened so any 6-bit cell index is a legal bit select.
    logic [63:0] p_mask_w;
    logic [63:0] c_mask_w;
    logic [5:0]  p_idx;
    logic [5:0]  c_idx;
    logic        p_acc, p_rej, c_acc, c_rej, tmo_fire, resolving;
    logic [2:0]  p_hits_nxt;
    logic [2:0]  c_hits_nxt;

    assign p_mask_w = 64'(p_mask);
    assign c_mask_w = 64'(c_mask);
    assign p_idx    = cell_idx(player_x, player_y);
    assign c_idx    = cell_idx(pc_x, pc_y);

    assign p_acc = (state == PLAYER_TURN) && player_shot_vld &&
                   in_range(player_x, player_y) && !p_mask_w[p_idx];
    assign p_rej = (state == PLAYER_TURN) && player_shot_vld && !p_acc;
    assign c_acc = (state == PC_TURN) && pc_shot_vld &&
                   in_range(pc_x, pc_y) && !c_mask_w[c_idx];
    assign c_rej = (state == PC_TURN) && pc_shot_vld && !c_acc;

    // An accepted shot on the last idle cycle takes priority over the forfeit.
    assign tmo_fire  = TMO_EN && (state == PLAYER_TURN) && (tmo_cnt == TMO_LAST) && !p_acc;
    assign resolving = (state == PLAYER_RESOLVE) || (state == PC_RESOLVE);

    assign p_hits_nxt = (rd_hit && p_hits_r != NS) ? p_hits_r + 3'd1 : p_hits_r;
    assign c_hits_nxt = (rd_hit && c_hits_r != NS) ? c_hits_r + 3'd1 : c_hits_r;

    assign shot_ack        = p_acc || c_acc;
    assign shot_nack       = p_rej || c_rej;
    assign rd_en           = p_acc || c_acc;
    assign rd_sel          = c_acc || (state == PC_RESOLVE);
    assign mark_we         = resolving;
    assign mark_hit        = resolving && rd_hit;
    assign timeout         = tmo_fire;
    assign en_player_setup = (state == SETUP_P);
    assign en_pc_setup     = (state == SETUP_PC);
    assign player_turn     = (state == PLAYER_TURN) || (state == PLAYER_RESOLVE);
    assign game_over       = (state == GAME_OVER);
    assign player_hits     = p_hits_r;
    assign pc_hits         = c_hits_r;
    assign winner          = winner_r;

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if (p_acc) begin
            rd_x = player_x;
            rd_y = player_y;
        end else if (c_acc) begin
            rd_x = pc_x;
            rd_y = pc_y;
        end else if (resolving) begin
            rd_x = lat_x;
            rd_y = lat_y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            p_mask   <= '0;
            c_mask   <= '0;
            lat_x    <= '0;
            lat_y    <= '0;
            lat_idx  <= '0;
            tmo_cnt  <= '0;
            p_hits_r <= '0;
            c_hits_r <= '0;
            winner_r <= 1'b0;
        end else begin
            // Every entry into PLAYER_TURN comes from another state, so the count starts at zero.
            tmo_cnt <= (state == PLAYER_TURN) ? tmo_cnt + TW'(1) : '0;
            case (state)
                IDLE: if (start) begin
                    state    <= SETUP_P;
                    p_mask   <= '0;
                    c_mask   <= '0;
                    p_hits_r <= '0;
                    c_hits_r <= '0;
                    winner_r <= 1'b0;
                end
                SETUP_P:  if (player_end_setup) state <= SETUP_PC;
                SETUP_PC: if (pc_end_setup)     state <= PLAYER_TURN;
                PLAYER_TURN: begin
                    if (p_acc) begin
                        lat_x   <= player_x;
                        lat_y   <= player_y;
                        lat_idx <= p_idx;
                        state   <= PLAYER_RESOLVE;
                    end else if (tmo_fire) begin
                        state <= PC_TURN;
                    end
                end
                PLAYER_RESOLVE: begin
                    p_mask   <= p_mask | CELLS'(64'd1 << lat_idx);
                    p_hits_r <= p_hits_nxt;
                    if (p_hits_nxt == NS) begin
                        winner_r <= 1'b0;
                        state    <= GAME_OVER;
                    end else begin
                        state <= PC_TURN;
                    end
                end
                PC_TURN: if (c_acc) begin
                    lat_x   <= pc_x;
                    lat_y   <= pc_y;
                    lat_idx <= c_idx;
                    state   <= PC_RESOLVE;
                end
                PC_RESOLVE: begin
                    c_mask   <= c_mask | CELLS'(64'd1 << lat_idx);
                    c_hits_r <= c_hits_nxt;
                    if (c_hits_nxt == NS) begin
                        winner_r <= 1'b1;
                        state    <= GAME_OVER;
                    end else begin
                        state <= PLAYER_TURN;
                    end
                end
                GAME_OVER: if (restart) begin
                    state    <= IDLE;
                    p_hits_r <= '0;
                    c_hits_r <= '0;
                    winner_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
